// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage.
// Holds the PC, issues one instruction-memory request at a time, presents the
// fetched word with its PC and PC+4 to decode, and picks the next PC on accept.
// Ports:
//   clk, rst                       clock, async active-high reset
//   stall                          decode cannot accept the held instruction
//   branch_taken, branch_offset    taken branch, unshifted sign-extended word offset
//   jump, jump_target              J/JAL with raw instr[25:0]
//   jump_reg, jump_reg_addr        JR/JALR with register-sourced target
//   imem_req, imem_addr            fetch request and address (current PC)
//   imem_ready, imem_rdata         fetch response
//   instr_valid, instr, instr_pc, pc_plus4   fetched instruction to decode
//   pc_misalign                    sticky: a jump_reg target had nonzero [1:0]
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        pc_misalign
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_W = {RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
    logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
    logic              instr_valid_q, instr_valid_d;
    logic              imem_req_q, imem_req_d;
    logic              pc_misalign_q, pc_misalign_d;
    logic [XLEN-1:0]   next_pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ready) state_d = HOLD;
            HOLD:    if (!stall) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Redirect mux: jump_reg > jump > branch > sequential, all modulo 2^32
    always_comb begin
        next_pc = pc_plus4_q;
        if (jump_reg) begin
            next_pc = {jump_reg_addr[XLEN-1:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4_q[XLEN-1:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4_q + (branch_offset << 2);
        end
    end

    // Output / datapath next values
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_valid_d = instr_valid_q;
        pc_misalign_d = pc_misalign_q;
        // Request is registered: it follows the state being entered
        imem_req_d    = (state_d == FETCH);
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    pc_plus4_d    = pc_q + XLEN'(4);
                    instr_valid_d = 1'b1;
                end
            end
            HOLD: begin
                // Redirect inputs only matter on the accept edge
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    if (jump_reg && (jump_reg_addr[1:0] != 2'b00)) begin
                        pc_misalign_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC_W;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC_W;
            pc_plus4_q    <= RESET_PC_W + XLEN'(4);
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            pc_misalign_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            pc_misalign_q <= pc_misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign pc_misalign = pc_misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed stimulus, scoreboard queues filled
// by the driver and drained by a negedge monitor. A second instance with
// RESET_PC = 32'hFFFF_FFFC shares all inputs to cover PC wrap.
module tb_pc_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] jump_reg_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata0, imem_rdata1;

    logic        imem_req0, imem_req1;
    logic [31:0] imem_addr0, imem_addr1;
    logic        instr_valid0, instr_valid1;
    logic [31:0] instr0, instr1, instr_pc0, instr_pc1, pc_plus4_0, pc_plus4_1;
    logic        pc_misalign0, pc_misalign1;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
        .imem_req(imem_req0), .imem_addr(imem_addr0),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata0),
        .instr_valid(instr_valid0), .instr(instr0), .instr_pc(instr_pc0),
        .pc_plus4(pc_plus4_0), .pc_misalign(pc_misalign0)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
        .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata1),
        .instr_valid(instr_valid1), .instr(instr1), .instr_pc(instr_pc1),
        .pc_plus4(pc_plus4_1), .pc_misalign(pc_misalign1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: answers after mem_delay wait cycles; force_ready injects
    // a spurious response carrying a poison word.
    int   mem_delay = 0;
    int   mem_cnt   = 0;
    logic mem_ready_r = 1'b0;
    logic force_ready = 1'b0;
    assign imem_ready  = mem_ready_r | force_ready;
    assign imem_rdata0 = force_ready ? 32'hDEAD_BEEF : (imem_addr0 ^ KEY);
    assign imem_rdata1 = force_ready ? 32'hDEAD_BEEF : (imem_addr1 ^ KEY);

    always @(negedge clk) begin
        if (rst || !imem_req0) begin
            mem_cnt     = 0;
            mem_ready_r = 1'b0;
        end else if (mem_cnt >= mem_delay) begin
            mem_ready_r = 1'b1;
        end else begin
            mem_cnt++;
        end
    end

    // Scoreboard
    logic [31:0] exp_pc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_addr1[$];
    logic        sb1_en   = 1'b0;
    logic        chk_rate = 1'b0;
    int          cyc       = 0;
    int          last_rise = -1;
    logic        pv_valid = 1'b0, pv_req = 1'b0, pv_req1 = 1'b0;
    logic [31:0] p, a;

    always @(negedge clk) begin
        cyc++;
        if (instr_valid0 && !pv_valid) begin
            if (exp_pc.size() == 0) begin
                check("unexpected_instr", instr_pc0, 32'hXXXX_XXXX);
            end else begin
                p = exp_pc.pop_front();
                check("instr", instr0, p ^ KEY);
                check("instr_pc", instr_pc0, p);
                check("pc_plus4", pc_plus4_0, p + 32'd4);
                if (chk_rate && last_rise >= 0) check("valid_period", 32'(cyc - last_rise), 32'd2);
                last_rise = cyc;
            end
        end
        if (imem_req0 && !pv_req) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_req", imem_addr0, 32'hXXXX_XXXX);
            end else begin
                a = exp_addr.pop_front();
                check("imem_addr", imem_addr0, a);
            end
        end
        if (sb1_en && imem_req1 && !pv_req1) begin
            if (exp_addr1.size() == 0) begin
                check("unexpected_req_wrap", imem_addr1, 32'hXXXX_XXXX);
            end else begin
                a = exp_addr1.pop_front();
                check("imem_addr_wrap", imem_addr1, a);
            end
        end
        pv_valid = instr_valid0;
        pv_req   = imem_req0;
        pv_req1  = imem_req1;
    end

    task automatic clear_redirects();
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        jump_reg      = 1'b0;
        jump_reg_addr = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_redirects();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_imem_req", 32'(imem_req0), 32'd0);
        check("rst_imem_addr", imem_addr0, 32'h0);
        check("rst_instr_valid", 32'(instr_valid0), 32'd0);
        check("rst_instr", instr0, 32'h0);
        check("rst_instr_pc", instr_pc0, 32'h0);
        check("rst_pc_plus4", pc_plus4_0, 32'h4);
        check("rst_pc_misalign", 32'(pc_misalign0), 32'd0);
        check("rst_imem_addr_wrap", imem_addr1, 32'hFFFF_FFFC);
        check("rst_pc_plus4_wrap", pc_plus4_1, 32'h0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_valid", 32'(instr_valid0), 32'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_req", 32'(imem_req0), 32'd1);
    endtask

    // Wait for the held instruction, accept it with the given redirects
    task automatic step(input logic jr, input logic [31:0] jra,
                        input logic j, input logic [25:0] jt,
                        input logic bt, input logic [31:0] bo);
        wait_valid();
        jump_reg      = jr;
        jump_reg_addr = jra;
        jump          = j;
        jump_target   = jt;
        branch_taken  = bt;
        branch_offset = bo;
        stall         = 1'b0;
        @(negedge clk);
        clear_redirects();
        stall = 1'b1;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        clear_redirects();

        // Zero-wait sequential fetch, one instruction per two cycles
        @(negedge clk);
        #1 check_reset();
        @(negedge clk);
        mem_delay = 0;
        exp_pc    = '{32'h0, 32'h4, 32'h8};
        exp_addr  = '{32'h0, 32'h4, 32'h8};
        exp_addr1 = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        sb1_en    = 1'b1;
        chk_rate  = 1'b1;
        last_rise = -1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            if (k == 2) stall = 1'b1;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Slow memory then a four-cycle stall in HOLD
        sb1_en   = 1'b0;
        chk_rate = 1'b0;
        apply_reset();
        mem_delay = 3;
        stall     = 1'b1;
        exp_pc    = '{32'h0, 32'h4};
        exp_addr  = '{32'h0, 32'h4};
        rst = 1'b0;
        wait_req();
        for (int i = 0; i < 3; i++) begin
            check("wait_req", 32'(imem_req0), 32'd1);
            check("wait_addr", imem_addr0, 32'h0);
            check("wait_valid", 32'(instr_valid0), 32'd0);
            @(negedge clk);
        end
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            check("stall_instr", instr0, KEY);
            check("stall_instr_pc", instr_pc0, 32'h0);
            check("stall_req", 32'(imem_req0), 32'd0);
            check("stall_valid", 32'(instr_valid0), 32'd1);
            @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        wait_valid();
        repeat (2) @(negedge clk);

        // Redirect priority and targets
        apply_reset();
        mem_delay = 0;
        stall     = 1'b1;
        exp_pc    = '{32'h0, 32'h100, 32'hF4, 32'h9000_0000, 32'h9000_0100,
                      32'h2000, 32'h2004, 32'h0FFF_FFFC, 32'h1000_0004};
        exp_addr  = exp_pc;
        rst = 1'b0;
        wait_valid();
        // Redirects while stalled must be ignored
        jump_reg = 1'b1; jump_reg_addr = 32'h5; branch_taken = 1'b1;
        @(negedge clk);
        clear_redirects();
        check("ignored_misalign", 32'(pc_misalign0), 32'd0);
        check("ignored_instr_pc", instr_pc0, 32'h0);
        step(1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 32'h9000_0000, 1'b0, 26'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 26'h000_0040, 1'b0, 32'h0);
        wait_valid();
        check("pre_misalign", 32'(pc_misalign0), 32'd0);
        step(1'b1, 32'h0000_2003, 1'b1, 26'h000_0123, 1'b1, 32'h10);
        check("misalign_set", 32'(pc_misalign0), 32'd1);
        step(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h40);
        step(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1);
        wait_valid();
        check("misalign_sticky", 32'(pc_misalign0), 32'd1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a fetch with a late response
        apply_reset();
        mem_delay = 5;
        stall     = 1'b1;
        exp_pc    = '{32'h0};
        exp_addr  = '{32'h0, 32'h0};
        rst = 1'b0;
        wait_req();
        @(negedge clk);
        rst         = 1'b1;
        force_ready = 1'b1;
        mem_delay   = 0;
        #1 check_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        force_ready = 1'b0;
        wait_valid();
        repeat (3) @(negedge clk);

        check("sb_pc_drain", 32'(exp_pc.size()), 32'd0);
        check("sb_addr_drain", 32'(exp_addr.size()), 32'd0);
        check("sb_addr_wrap_drain", 32'(exp_addr1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the MIPS datapath.
- Holds the PC, issues one instruction-memory request at a time, and presents the fetched instruction with its PC and PC+4 to decode.
- On acceptance of each instruction, selects the next PC from four sources: sequential, branch, jump and jump-register.
- Consumes the decode/execute redirect results; computes the branch target (offset<<2) and the jump target ({PC+4[31:28], target, 2'b00}) internally.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept the presented instruction this cycle
- branch_taken  in  1  accepted instruction is a taken branch
- branch_offset  in  32  sign-extended 16-bit immediate (word offset, not yet shifted)
- jump  in  1  accepted instruction is J/JAL
- jump_target  in  26  raw instr[25:0]
- jump_reg  in  1  accepted instruction is JR/JALR
- jump_reg_addr  in  32  register-sourced target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (current PC)
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched word
- instr_valid  out  1  instr/instr_pc/pc_plus4 valid
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- pc_plus4  out  32  instr_pc + 4
- pc_misalign  out  1  sticky flag: a jump_reg target had nonzero bits [1:0]

Behaviour:
- Reset (async, immediate): state=IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=RESET_PC; pc_plus4=RESET_PC+4; pc_misalign=0.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: no request. Moves to FETCH on the first clock after rst deasserts.
  - FETCH: imem_req=1, imem_addr=pc, both stable until imem_ready. Memory may wait any number of cycles.
    - On an edge with imem_ready=1: instr<=imem_rdata; instr_pc<=pc; pc_plus4<=pc+4; instr_valid<=1; state<=HOLD.
  - HOLD: imem_req=0; instr_valid=1; all instr outputs held.
    - Edge with stall=1: no change.
    - Edge with stall=0 (accept): instr_valid<=0; pc<=next_pc; state<=FETCH.
- Redirect inputs are sampled only on the accept edge; they are ignored in every other state or cycle.
- Minimum throughput: one instruction per 2 cycles with zero-wait memory. Latency from request to instr_valid is 1 cycle after imem_ready.
- next_pc priority, highest first:
  1. jump_reg: {jump_reg_addr[31:2], 2'b00}. If jump_reg_addr[1:0]!=0, pc_misalign<=1 (sticky until rst).
  2. jump: {pc_plus4[31:28], jump_target, 2'b00}.
  3. branch_taken: pc_plus4 + {branch_offset[29:0], 2'b00}.
  4. Otherwise: pc_plus4.
- Arithmetic: all adds are 32-bit modulo 2^32; carry out is discarded. PC 32'hFFFF_FFFC sequential wraps to 0. Branch targets wrap the same way.
- Simultaneous redirect flags resolve by the priority above with no error.
- Reset mid-fetch: a pending request is dropped and a late imem_ready after reset is ignored. A fresh fetch of RESET_PC starts via IDLE.
- imem_ready while not in FETCH is ignored.
- PC is always word-aligned; bits [1:0] of pc, imem_addr and instr_pc are always 0.

Test Plan:
- Reset, zero-wait memory returning addr-based words, stall=0 → imem_addr sequence 0x0, 0x4, 0x8; instr_valid every 2nd cycle; pc_plus4 = instr_pc+4.
- imem_ready delayed 3 cycles, then stall=1 for 4 cycles in HOLD → imem_addr stable for the wait; instr/instr_pc unchanged for the stall; no new request until accept.
- At instr_pc=0x100, branch_taken, branch_offset=32'hFFFF_FFFC → next imem_addr=0xF4. Then jump, jump_target=26'h000_0040, pc_plus4=0x9000_0004 → next imem_addr=0x9000_0100.
- jump_reg=1 and jump=1 and branch_taken=1, jump_reg_addr=0x2003 → next imem_addr=0x2000; pc_misalign rises and stays 1 across later fetches.
- RESET_PC=32'hFFFF_FFFC, sequential accept → next imem_addr=0x0000_0000.
- rst asserted mid-FETCH with imem_ready pulsed during reset → outputs at reset values immediately; after release, first request is RESET_PC and the stale data never appears on instr.
